// File: rtl/preamble_tx_pkg.sv
// Shared types, frame geometry and the 802.11 legacy preamble sample tables for preamble_tx.
// Samples are {I,Q} Q1.15; table entries are written in thousandths of full scale.
package preamble_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STS    = 3'd1,
    S_LTS_GI = 3'd2,
    S_LTS    = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam int STS_LEN      = 16;
  localparam int STS_REPS     = 10;
  localparam int LTS_LEN      = 64;
  localparam int GI2_LEN      = 32;
  localparam int PREAMBLE_LEN = 320;

  // Convert a (re, im) pair given in thousandths into a packed Q1.15 {I,Q} word.
  function automatic logic [31:0] iq(input int re_m, input int im_m);
    int v_re;
    int v_im;
    v_re = (re_m * 32768) / 1000;
    v_im = (im_m * 32768) / 1000;
    return {v_re[15:0], v_im[15:0]};
  endfunction

  // Arithmetic right shift applied independently to the I and Q halves.
  function automatic logic [31:0] scale_iq(input logic [31:0] s, input logic [2:0] sh);
    logic signed [15:0] v_i;
    logic signed [15:0] v_q;
    v_i = $signed(s[31:16]) >>> sh;
    v_q = $signed(s[15:0]) >>> sh;
    return {v_i, v_q};
  endfunction

  localparam logic [31:0] STS_ROM [STS_LEN] = '{
    iq(  46,   46), iq(-132,    2), iq( -13,  -79), iq( 143,  -13),
    iq(  92,    0), iq( 143,  -13), iq( -13,  -79), iq(-132,    2),
    iq(  46,   46), iq(   2, -132), iq( -79,  -13), iq( -13,  143),
    iq(   0,   92), iq( -13,  143), iq( -79,  -13), iq(   2, -132)
  };

  localparam logic [31:0] LTS_ROM [LTS_LEN] = '{
    iq( 156,    0), iq(  -5, -120), iq(  40, -111), iq(  97,   83),
    iq(  21,   28), iq(  60,  -88), iq(-115,  -55), iq( -38, -106),
    iq(  98,  -26), iq(  53,    4), iq(   1, -115), iq(-137,  -47),
    iq(  24,  -59), iq(  59,  -15), iq( -22,  161), iq( 119,   -4),
    iq(  62,   62), iq(  37,  -98), iq( -57,  -39), iq(-131,  -65),
    iq(  82,  -92), iq(  70,  -14), iq( -60,  -81), iq( -56,   22),
    iq( -35,  151), iq(-122,   17), iq(-127,   21), iq(  75,   74),
    iq(  -3,  -54), iq( -92,  115), iq(  92,  106), iq(  12,   98),
    iq(-156,    0), iq(  12,  -98), iq(  92, -106), iq( -92, -115),
    iq(  -3,   54), iq(  75,  -74), iq(-127,  -21), iq(-122,  -17),
    iq( -35, -151), iq( -56,  -22), iq( -60,   81), iq(  70,   14),
    iq(  82,   92), iq(-131,   65), iq( -57,   39), iq(  37,   98),
    iq(  62,  -62), iq( 119,    4), iq( -22, -161), iq(  59,   15),
    iq(  24,   59), iq(-137,   47), iq(   1,  115), iq(  53,   -4),
    iq(  98,   26), iq( -38,  106), iq(-115,   55), iq(  60,   88),
    iq(  21,  -28), iq(  97,  -83), iq(  40,  111), iq(  -5,  120)
  };

endpackage

// File: rtl/preamble_tx_if.sv
// AXI-Stream {I,Q} sample channel between preamble_tx and the upsampler/DAC or loopback path.
interface preamble_tx_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/preamble_tx_rom.sv
// Combinational preamble sample lookup: STS uses addr[3:0], LTS uses the full 6-bit address.
module preamble_rom
  import preamble_pkg::*;
(
  input  logic        i_is_lts,
  input  logic [5:0]  i_addr,
  output logic [31:0] o_sample
);

  // Table select
  always_comb begin
    o_sample = 32'd0;
    if (i_is_lts) begin
      o_sample = LTS_ROM[i_addr];
    end else begin
      o_sample = STS_ROM[i_addr[3:0]];
    end
  end

endmodule

// File: rtl/preamble_tx.sv
// 802.11 legacy preamble burst generator (STS, GI2+2xLTS, optional zero gap) on an AXI-Stream master.
// Define PREAMBLE_TX_WINDOW_EN to halve beats 0 and 319 as edge windowing.
module preamble_tx
  import preamble_pkg::*;
#(
  parameter int GAP_LEN = 0
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic          abort_in,
  input  logic [1:0]    gain_in,
  preamble_tx_if.master tx_axis,
  output logic          busy_out,
  output logic [15:0]   frame_cnt_out
);

  localparam logic [8:0] STS_END  = 9'(STS_LEN * STS_REPS);
  localparam logic [8:0] GI_END   = 9'(STS_LEN * STS_REPS + GI2_LEN);
  localparam logic [8:0] ROM_END  = 9'(PREAMBLE_LEN);
  localparam logic [8:0] LAST_IDX = 9'(PREAMBLE_LEN - 1 + GAP_LEN);

  state_t      r_state;
  logic [8:0]  r_idx;
  logic [1:0]  r_gain;
  logic        r_abort;
  logic        r_busy;
  logic [15:0] r_frame_cnt;
  logic        r_tvalid;
  logic [31:0] r_tdata;
  logic        r_tlast;

  state_t      w_state_nxt;
  logic [8:0]  w_idx_nxt;
  logic [1:0]  w_gain_nxt;
  logic        w_abort_nxt;
  logic        w_busy_nxt;
  logic [15:0] w_frame_nxt;
  logic        w_tvalid_nxt;
  logic [31:0] w_tdata_nxt;
  logic        w_tlast_nxt;

  logic        w_hs;
  logic [8:0]  w_load_idx;
  logic [1:0]  w_gain_use;
  state_t      w_load_state;
  logic        w_is_rom;
  logic        w_is_lts;
  logic [5:0]  w_rom_addr;
  logic [31:0] w_rom_sample;
  logic        w_win;
  logic [2:0]  w_shift;
  logic [31:0] w_sample;

  assign w_hs = r_tvalid && tx_axis.tready;

  // The beat being loaded is idx 0 on start, otherwise the successor of the beat just accepted.
  assign w_load_idx = (r_state == S_IDLE) ? 9'd0 : (r_idx + 9'd1);
  assign w_gain_use = (r_state == S_IDLE) ? gain_in : r_gain;

  assign w_is_rom   = (w_load_idx < ROM_END);
  assign w_is_lts   = (w_load_idx >= STS_END);
  assign w_rom_addr = w_is_lts ? w_load_idx[5:0] : {2'b00, w_load_idx[3:0]};

  preamble_rom u_rom (
    .i_is_lts (w_is_lts),
    .i_addr   (w_rom_addr),
    .o_sample (w_rom_sample)
  );

`ifdef PREAMBLE_TX_WINDOW_EN
  assign w_win = (w_load_idx == 9'd0) || (w_load_idx == 9'(PREAMBLE_LEN - 1));
`else
  assign w_win = 1'b0;
`endif

  assign w_shift  = {1'b0, w_gain_use} + {2'b00, w_win};
  assign w_sample = w_is_rom ? scale_iq(w_rom_sample, w_shift) : 32'd0;

  // Segment of the burst that the loaded index falls in
  always_comb begin
    w_load_state = S_GAP;
    if (w_load_idx < STS_END) begin
      w_load_state = S_STS;
    end else if (w_load_idx < GI_END) begin
      w_load_state = S_LTS_GI;
    end else if (w_load_idx < ROM_END) begin
      w_load_state = S_LTS;
    end else begin
      w_load_state = S_GAP;
    end
  end

  // FSM next state and output-register next values
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_gain_nxt   = r_gain;
    w_abort_nxt  = r_abort;
    w_busy_nxt   = r_busy;
    w_frame_nxt  = r_frame_cnt;
    w_tvalid_nxt = r_tvalid;
    w_tdata_nxt  = r_tdata;
    w_tlast_nxt  = r_tlast;
    case (r_state)
      S_IDLE: begin
        w_abort_nxt = 1'b0;
        if (start_in) begin
          w_gain_nxt   = gain_in;
          w_busy_nxt   = 1'b1;
          w_tvalid_nxt = 1'b1;
          w_idx_nxt    = w_load_idx;
          w_state_nxt  = w_load_state;
          w_tdata_nxt  = w_sample;
          w_tlast_nxt  = (w_load_idx == LAST_IDX);
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_STS, S_LTS_GI, S_LTS, S_GAP: begin
        if (w_hs && r_tlast) begin
          // Final beat accepted, whether natural or the abort terminator.
          w_state_nxt  = S_IDLE;
          w_idx_nxt    = 9'd0;
          w_abort_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_frame_nxt  = r_frame_cnt + 16'd1;
          w_tvalid_nxt = 1'b0;
          w_tdata_nxt  = 32'd0;
          w_tlast_nxt  = 1'b0;
        end else if (w_hs && (r_abort || abort_in)) begin
          w_abort_nxt = 1'b1;
          w_tdata_nxt = 32'd0;
          w_tlast_nxt = 1'b1;
        end else if (w_hs) begin
          w_idx_nxt   = w_load_idx;
          w_state_nxt = w_load_state;
          w_tdata_nxt = w_sample;
          w_tlast_nxt = (w_load_idx == LAST_IDX);
        end else begin
          w_abort_nxt = r_abort || abort_in;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_idx_nxt    = 9'd0;
        w_abort_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_tvalid_nxt = 1'b0;
        w_tdata_nxt  = 32'd0;
        w_tlast_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_idx       <= 9'd0;
      r_gain      <= 2'd0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_tvalid    <= 1'b0;
      r_tdata     <= 32'd0;
      r_tlast     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_gain      <= w_gain_nxt;
      r_abort     <= w_abort_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_tvalid    <= w_tvalid_nxt;
      r_tdata     <= w_tdata_nxt;
      r_tlast     <= w_tlast_nxt;
    end
  end

  assign tx_axis.tvalid = r_tvalid;
  assign tx_axis.tdata  = r_tdata;
  assign tx_axis.tlast  = r_tlast;
  assign busy_out       = r_busy;
  assign frame_cnt_out  = r_frame_cnt;

endmodule
